// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl
// Controller for a number-guessing game. It latches a secret and accepts
// guesses one at a time. It drives an external combinational magnitude
// comparator and turns the comparator flags into hints, a try count and a
// final win/lose status.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, secret_in       begin a game (IDLE/WIN/LOSE), latch the secret
//   guess_valid, guess     guess offered to the controller
//   guess_ready            a guess is accepted when guess_valid && guess_ready
//   cmp_a, cmp_b           comparator operands (registered guess / secret)
//   a_less_b, a_greater_b,
//   a_equal_b              comparator flags, consumed in CHECK
//   hint_high, hint_low    direction hint for the last wrong guess
//   tries                  guesses accepted in the current game
//   win, lose, err         terminal status; err = flags were not one-hot
//   busy                   a game is in progress (WAIT_GUESS or CHECK)
//
// Handshake: a guess transfers on a rising edge where guess_valid and
// guess_ready are both high. guess_ready depends only on the state, never
// on guess_valid. The guess is held in cmp_a from that point on.
module guess_game_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MAX_TRIES = 7,
    parameter int TRY_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] secret_in,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    output logic             guess_ready,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             a_less_b,
    input  logic             a_greater_b,
    input  logic             a_equal_b,
    output logic             hint_high,
    output logic             hint_low,
    output logic [TRY_W-1:0] tries,
    output logic             win,
    output logic             lose,
    output logic             err,
    output logic             busy
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_GUESS = 3'd1;
    localparam logic [2:0] CHECK      = 3'd2;
    localparam logic [2:0] WIN        = 3'd3;
    localparam logic [2:0] LOSE       = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
    logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             hint_high_q, hint_high_d;
    logic             hint_low_q, hint_low_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             err_q, err_d;

    logic [2:0] flags;
    logic       flags_one_hot;

    assign flags         = {a_less_b, a_greater_b, a_equal_b};
    assign flags_one_hot = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);

    always_comb begin
        state_d     = state_q;
        cmp_a_d     = cmp_a_q;
        cmp_b_d     = cmp_b_q;
        tries_d     = tries_q;
        hint_high_d = hint_high_q;
        hint_low_d  = hint_low_q;
        win_d       = win_q;
        lose_d      = lose_q;
        err_d       = err_q;

        case (state_q)
            // A new game starts the same way from idle or from a finished game.
            IDLE, WIN, LOSE: begin
                if (start) begin
                    cmp_b_d     = secret_in;
                    tries_d     = '0;
                    hint_high_d = 1'b0;
                    hint_low_d  = 1'b0;
                    win_d       = 1'b0;
                    lose_d      = 1'b0;
                    err_d       = 1'b0;
                    state_d     = WAIT_GUESS;
                end
            end
            WAIT_GUESS: begin
                if (guess_valid) begin
                    cmp_a_d = guess;
                    tries_d = tries_q + TRY_W'(1);
                    state_d = CHECK;
                end
            end
            // Operands were registered on entry, so the comparator flags are
            // settled by the end of this single cycle.
            CHECK: begin
                if (!flags_one_hot) begin
                    err_d   = 1'b1;
                    lose_d  = 1'b1;
                    state_d = LOSE;
                end else if (a_equal_b) begin
                    // Checked before the try limit: a hit on the last try wins.
                    win_d       = 1'b1;
                    hint_high_d = 1'b0;
                    hint_low_d  = 1'b0;
                    state_d     = WIN;
                end else begin
                    hint_high_d = a_greater_b;
                    hint_low_d  = a_less_b;
                    if (tries_q == TRY_W'(MAX_TRIES)) begin
                        lose_d  = 1'b1;
                        state_d = LOSE;
                    end else begin
                        state_d = WAIT_GUESS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            tries_q     <= '0;
            hint_high_q <= 1'b0;
            hint_low_q  <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            tries_q     <= tries_d;
            hint_high_q <= hint_high_d;
            hint_low_q  <= hint_low_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            err_q       <= err_d;
        end
    end

    assign guess_ready = (state_q == WAIT_GUESS);
    assign busy        = (state_q == WAIT_GUESS) || (state_q == CHECK);
    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign tries       = tries_q;
    assign hint_high   = hint_high_q;
    assign hint_low    = hint_low_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign err         = err_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl. A behavioural magnitude comparator
// feeds the flag inputs from cmp_a/cmp_b; it can be overridden to inject
// illegal flag patterns during CHECK.
module tb_guess_game_ctrl;

    localparam int WIDTH     = 4;
    localparam int MAX_TRIES = 7;
    localparam int TRY_W     = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] secret_in;
    logic             guess_valid;
    logic [WIDTH-1:0] guess;
    logic             guess_ready;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             a_less_b;
    logic             a_greater_b;
    logic             a_equal_b;
    logic             hint_high;
    logic             hint_low;
    logic [TRY_W-1:0] tries;
    logic             win;
    logic             lose;
    logic             err;
    logic             busy;

    logic             force_en;
    logic [2:0]       force_flags;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Comparator model: {less, greater, equal}, or the injected pattern.
    assign {a_less_b, a_greater_b, a_equal_b} = force_en ? force_flags :
        {(cmp_a < cmp_b), (cmp_a > cmp_b), (cmp_a == cmp_b)};

    guess_game_ctrl #(
        .WIDTH    (WIDTH),
        .MAX_TRIES(MAX_TRIES),
        .TRY_W    (TRY_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .secret_in  (secret_in),
        .guess_valid(guess_valid),
        .guess      (guess),
        .guess_ready(guess_ready),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .a_less_b   (a_less_b),
        .a_greater_b(a_greater_b),
        .a_equal_b  (a_equal_b),
        .hint_high  (hint_high),
        .hint_low   (hint_low),
        .tries      (tries),
        .win        (win),
        .lose       (lose),
        .err        (err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs {win, lose, err, hint_high, hint_low, busy, guess_ready}.
    function automatic logic [6:0] status();
        return {win, lose, err, hint_high, hint_low, busy, guess_ready};
    endfunction

    task automatic start_game(input logic [WIDTH-1:0] s);
        start     = 1'b1;
        secret_in = s;
        step();
        start     = 1'b0;
    endtask

    // Present a guess for the accept edge, then run the CHECK edge with the
    // comparator model or with injected flags.
    task automatic do_guess(input logic [WIDTH-1:0] g, input logic fe, input logic [2:0] ff);
        guess_valid = 1'b1;
        guess       = g;
        step();
        guess_valid = 1'b0;
        force_en    = fe;
        force_flags = ff;
        step();
        force_en    = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        secret_in   = '0;
        guess_valid = 1'b0;
        guess       = '0;
        force_en    = 1'b0;
        force_flags = 3'b000;

        // Reset, with start and guess_valid asserted to show reset wins.
        start       = 1'b1;
        guess_valid = 1'b1;
        step();
        step();
        start       = 1'b0;
        guess_valid = 1'b0;
        chk("reset_status", status(), 7'b0000000);
        chk("reset_tries", tries, 0);
        chk("reset_cmp_a", cmp_a, 0);
        chk("reset_cmp_b", cmp_b, 0);
        rst_n = 1'b1;
        step();
        chk("idle_no_start", status(), 7'b0000000);

        // Game 1: secret 9, guesses 3, 12, 9.
        start_game(4'd9);
        chk("g1_start_status", status(), 7'b0000011);
        chk("g1_cmp_b", cmp_b, 9);
        chk("g1_tries0", tries, 0);
        guess_valid = 1'b1;
        guess       = 4'd3;
        step();
        guess_valid = 1'b0;
        chk("g1_accept_status", status(), 7'b0000010);
        chk("g1_accept_cmp_a", cmp_a, 3);
        chk("g1_accept_tries", tries, 1);
        step();
        chk("g1_after3", status(), 7'b0000111);
        step();
        chk("g1_after3_hold", status(), 7'b0000111);
        do_guess(4'd12, 1'b0, 3'b000);
        chk("g1_after12", status(), 7'b0001011);
        chk("g1_tries2", tries, 2);
        do_guess(4'd9, 1'b0, 3'b000);
        chk("g1_win", status(), 7'b1000000);
        chk("g1_win_tries", tries, 3);
        // Guesses are ignored once the game is won.
        guess_valid = 1'b1;
        guess       = 4'd1;
        step();
        step();
        guess_valid = 1'b0;
        chk("g1_ignored_cmp_a", cmp_a, 9);
        chk("g1_ignored_tries", tries, 3);
        chk("g1_win_hold", status(), 7'b1000000);

        // Game 2: secret 5, seven wrong guesses of 0.
        start_game(4'd5);
        chk("g2_restart_status", status(), 7'b0000011);
        chk("g2_restart_tries", tries, 0);
        for (int i = 1; i <= 6; i++) begin
            do_guess(4'd0, 1'b0, 3'b000);
            chk($sformatf("g2_low_%0d", i), status(), 7'b0000111);
            chk($sformatf("g2_tries_%0d", i), tries, i);
        end
        do_guess(4'd0, 1'b0, 3'b000);
        chk("g2_lose", status(), 7'b0100100);
        chk("g2_lose_tries", tries, 7);
        guess_valid = 1'b1;
        guess       = 4'd5;
        step();
        step();
        guess_valid = 1'b0;
        chk("g2_ignored_cmp_a", cmp_a, 0);
        chk("g2_ignored_tries", tries, 7);
        chk("g2_lose_hold", status(), 7'b0100100);

        // Game 3: secret 5, six wrong then correct on the final try.
        start_game(4'd5);
        do_guess(4'd1, 1'b0, 3'b000);
        do_guess(4'd2, 1'b0, 3'b000);
        do_guess(4'd3, 1'b0, 3'b000);
        do_guess(4'd4, 1'b0, 3'b000);
        do_guess(4'd6, 1'b0, 3'b000);
        chk("g3_high", status(), 7'b0001011);
        do_guess(4'd7, 1'b0, 3'b000);
        chk("g3_tries6", tries, 6);
        do_guess(4'd5, 1'b0, 3'b000);
        chk("g3_last_try_win", status(), 7'b1000000);
        chk("g3_tries7", tries, 7);

        // Game 4: no comparator flag set.
        start_game(4'd5);
        chk("g4_restart_status", status(), 7'b0000011);
        do_guess(4'd5, 1'b1, 3'b000);
        chk("g4_err_none", status(), 7'b0110000);
        chk("g4_tries", tries, 1);

        // Game 5: less and greater both set; err clears on restart.
        start_game(4'd5);
        chk("g5_err_cleared", status(), 7'b0000011);
        do_guess(4'd3, 1'b1, 3'b110);
        chk("g5_err_two", status(), 7'b0110000);

        // Game 6: reset during CHECK aborts to idle.
        start_game(4'd2);
        guess_valid = 1'b1;
        guess       = 4'd7;
        step();
        guess_valid = 1'b0;
        chk("g6_in_check", status(), 7'b0000010);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("g6_abort_status", status(), 7'b0000000);
        chk("g6_abort_tries", tries, 0);
        chk("g6_abort_cmp_a", cmp_a, 0);
        chk("g6_abort_cmp_b", cmp_b, 0);

        // Game 7: start in WAIT_GUESS is ignored; restart after a win.
        start_game(4'd2);
        start_game(4'd11);
        chk("g7_start_ignored_cmp_b", cmp_b, 2);
        chk("g7_start_ignored_status", status(), 7'b0000011);
        do_guess(4'd2, 1'b0, 3'b000);
        chk("g7_win", status(), 7'b1000000);
        start_game(4'd14);
        chk("g7_new_cmp_b", cmp_b, 14);
        chk("g7_new_tries", tries, 0);
        chk("g7_new_status", status(), 7'b0000011);

        // guess_valid held high: one acceptance per two-cycle round.
        guess_valid = 1'b1;
        guess       = 4'd4;
        step();
        chk("hold_acc1_cmp_a", cmp_a, 4);
        chk("hold_acc1_tries", tries, 1);
        guess = 4'd6;
        step();
        chk("hold_check1_cmp_a", cmp_a, 4);
        chk("hold_check1_tries", tries, 1);
        chk("hold_check1_status", status(), 7'b0000111);
        step();
        chk("hold_acc2_cmp_a", cmp_a, 6);
        chk("hold_acc2_tries", tries, 2);
        chk("hold_acc2_ready", guess_ready, 0);
        guess = 4'd15;
        step();
        chk("hold_check2_cmp_a", cmp_a, 6);
        chk("hold_check2_status", status(), 7'b0000111);
        step();
        guess_valid = 1'b0;
        chk("hold_acc3_cmp_a", cmp_a, 15);
        chk("hold_acc3_tries", tries, 3);
        step();
        chk("hold_check3_status", status(), 7'b0001011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
